// File: rtl/div_hilo_ctrl_pkg.sv
// Shared ALU constants for the HI/LO divide controller: FSM encoding,
// default divider settle time and two's-complement helpers.
package div_hilo_ctrl_pkg;

  // Default number of cycles granted to the combinational divider to settle
  localparam int unsigned DIV_WAIT_DEFAULT = 32'd4;

  // Divide sequencer states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_WAIT = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } div_state_e;

  // Two's-complement negation modulo 2^32
  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  // Magnitude of an operand: negative signed values are negated, everything else passes
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? neg32(v) : v;
  endfunction

endpackage

// File: rtl/div_hilo_ctrl_if.sv
// Request/result bundle between a CPU pipeline (master) and the HI/LO divide controller (slave).
interface div_hilo_if;
  logic        start;
  logic        signed_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic        dz;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, signed_op, dividend, divisor,
    input  busy, done, dz, hi, lo
  );

  modport slave (
    input  start, signed_op, dividend, divisor,
    output busy, done, dz, hi, lo
  );
endinterface

// File: rtl/div_hilo_ctrl_div32.sv
// Combinational 32-bit unsigned divider. A zero divisor yields an all-ones
// quotient and returns the dividend as remainder so no X ever propagates.
module div_32_bit (
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  // Unsigned quotient/remainder with a defined divide-by-zero result
  always_comb begin
    if (divisor == 32'd0) begin
      quotient  = 32'hFFFF_FFFF;
      remainder = dividend;
    end else begin
      quotient  = dividend / divisor;
      remainder = dividend % divisor;
    end
  end

endmodule

// File: rtl/div_hilo_ctrl.sv
// HI/LO divide controller: captures a DIV/DIVU request, strips signs, lets the
// combinational unsigned divider settle for DIV_WAIT cycles, restores signs and
// publishes quotient (lo) / remainder (hi) with a one-cycle done pulse.
module div_hilo_ctrl
  import div_hilo_ctrl_pkg::*;
#(
  parameter int unsigned DIV_WAIT = DIV_WAIT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  div_hilo_if.slave  bus
);

  localparam logic [3:0] WAIT_LAST = 4'(DIV_WAIT - 32'd1);

  div_state_e  state_q,     state_d;
  logic [31:0] dividend_q,  dividend_d;
  logic [31:0] divisor_q,   divisor_d;
  logic        signed_op_q, signed_op_d;
  logic [31:0] mag_a_q,     mag_a_d;
  logic [31:0] mag_b_q,     mag_b_d;
  logic        neg_quo_q,   neg_quo_d;
  logic        neg_rem_q,   neg_rem_d;
  logic [3:0]  cnt_q,       cnt_d;
  logic        busy_q,      busy_d;
  logic        done_q,      done_d;
  logic        dz_q,        dz_d;
  logic [31:0] hi_q,        hi_d;
  logic [31:0] lo_q,        lo_d;
  logic [31:0] udiv_quo_s;
  logic [31:0] udiv_rem_s;

  div_32_bit u_div (
    .dividend  (mag_a_q),
    .divisor   (mag_b_q),
    .quotient  (udiv_quo_s),
    .remainder (udiv_rem_s)
  );

  // Next-state and next-output logic for the divide sequence
  always_comb begin
    state_d     = state_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    signed_op_d = signed_op_q;
    mag_a_d     = mag_a_q;
    mag_b_d     = mag_b_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    dz_d        = dz_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          dividend_d  = bus.dividend;
          divisor_d   = bus.divisor;
          signed_op_d = bus.signed_op;
          state_d     = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        mag_a_d   = mag32(dividend_q, signed_op_q);
        mag_b_d   = mag32(divisor_q, signed_op_q);
        neg_quo_d = signed_op_q & (dividend_q[31] ^ divisor_q[31]);
        neg_rem_d = signed_op_q & dividend_q[31];
        cnt_d     = 4'd0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = ST_FIX;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_FIX: begin
        // Results become architecturally visible on entry to DONE
        done_d  = 1'b1;
        state_d = ST_DONE;
        if (divisor_q == 32'd0) begin
          lo_d = 32'hFFFF_FFFF;
          hi_d = dividend_q;
          dz_d = 1'b1;
        end else begin
          lo_d = neg_quo_q ? neg32(udiv_quo_s) : udiv_quo_s;
          hi_d = neg_rem_q ? neg32(udiv_rem_s) : udiv_rem_s;
          dz_d = 1'b0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers, cleared asynchronously by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      dividend_q  <= 32'd0;
      divisor_q   <= 32'd0;
      signed_op_q <= 1'b0;
      mag_a_q     <= 32'd0;
      mag_b_q     <= 32'd0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      cnt_q       <= 4'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dz_q        <= 1'b0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
    end else begin
      state_q     <= state_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      signed_op_q <= signed_op_d;
      mag_a_q     <= mag_a_d;
      mag_b_q     <= mag_b_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dz_q        <= dz_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.dz   = dz_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_div_hilo_ctrl.sv
// Directed bench for div_hilo_ctrl (DIV_WAIT = 4): latency, signed/unsigned
// results, divide-by-zero, overflow wrap, ignored starts and mid-operation reset.
module tb_div_hilo_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  div_hilo_if bus ();

  div_hilo_ctrl #(.DIV_WAIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request, scramble the inputs right after acceptance, wait for done
  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] h, output logic [31:0] l,
                        output logic z);
    @(negedge clk);
    bus.start = 1'b1; bus.signed_op = sgn; bus.dividend = a; bus.divisor = b;
    lat = 0; h = 32'd0; l = 32'd0; z = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (i == 1) begin
        bus.dividend = ~a; bus.divisor = ~b; bus.signed_op = ~sgn;
      end
      if (bus.done === 1'b1) begin
        lat = i; h = bus.hi; l = bus.lo; z = bus.dz;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0; bus.signed_op = 1'b0; bus.dividend = 32'd0; bus.divisor = 32'd0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.dz, bus.hi, bus.lo} !== 67'd0) begin
      errors++;
      $display("FAIL reset_state busy=%b done=%b dz=%b hi=%h lo=%h want all zero",
               bus.busy, bus.done, bus.dz, bus.hi, bus.lo);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_arith();
    logic        sg [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] va [7] = '{32'd100, 32'hFFFFFF9C, 32'd100, 32'h80000000, 32'hFFFFFFFF,
                            32'hFFFFFF9C, 32'hFFFFFF9C};
    logic [31:0] vb [7] = '{32'd7, 32'd7, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'd2,
                            32'hFFFFFFF9, 32'd7};
    logic [31:0] el [7] = '{32'h0000000E, 32'hFFFFFFF2, 32'hFFFFFFF2, 32'h80000000,
                            32'h7FFFFFFF, 32'h0000000E, 32'h24924916};
    logic [31:0] eh [7] = '{32'h00000002, 32'hFFFFFFFE, 32'h00000002, 32'h00000000,
                            32'h00000001, 32'hFFFFFFFE, 32'h00000002};
    int lat; logic [31:0] h, l; logic z;
    for (int k = 0; k < 7; k++) begin
      run_op(sg[k], va[k], vb[k], lat, h, l, z);
      checks++;
      if (lat !== 7 || l !== el[k] || h !== eh[k] || z !== 1'b0) begin
        errors++;
        $display("FAIL arith_%0d got lat=%0d lo=%h hi=%h dz=%b want lat=7 lo=%h hi=%h dz=0",
                 k, lat, l, h, z, el[k], eh[k]);
      end
    end
  endtask

  task automatic test_div_zero();
    int lat; logic [31:0] h, l; logic z;
    run_op(1'b0, 32'd5, 32'd0, lat, h, l, z);
    checks++;
    if (lat !== 7 || l !== 32'hFFFFFFFF || h !== 32'h5 || z !== 1'b1) begin
      errors++;
      $display("FAIL dz_5_0 got lat=%0d lo=%h hi=%h dz=%b want 7 ffffffff 00000005 1", lat, l, h, z);
    end
    run_op(1'b0, 32'd9, 32'd3, lat, h, l, z);
    checks++;
    if (lat !== 7 || l !== 32'h3 || h !== 32'h0 || z !== 1'b0) begin
      errors++;
      $display("FAIL after_dz_9_3 got lat=%0d lo=%h hi=%h dz=%b want 7 00000003 00000000 0", lat, l, h, z);
    end
    run_op(1'b1, 32'hFFFFFFFB, 32'd0, lat, h, l, z);
    checks++;
    if (lat !== 7 || l !== 32'hFFFFFFFF || h !== 32'hFFFFFFFB || z !== 1'b1) begin
      errors++;
      $display("FAIL dz_signed got lat=%0d lo=%h hi=%h dz=%b want 7 ffffffff fffffffb 1", lat, l, h, z);
    end
    // Results must hold while idle inputs wander
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.dividend = 32'h1234_0000 + 32'(i); bus.divisor = 32'(i); bus.signed_op = i[0];
    end
    checks++;
    if (bus.lo !== 32'hFFFFFFFF || bus.hi !== 32'hFFFFFFFB || bus.dz !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL hold got lo=%h hi=%h dz=%b busy=%b want ffffffff fffffffb 1 0",
               bus.lo, bus.hi, bus.dz, bus.busy);
    end
  endtask

  task automatic test_start_ignored();
    int ndone = 0; int lat = 0; logic [31:0] h = 32'd0, l = 32'd0;
    @(negedge clk);
    bus.start = 1'b1; bus.signed_op = 1'b0; bus.dividend = 32'd20; bus.divisor = 32'd6;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      bus.start = (i == 2);
      if (i == 2) begin bus.dividend = 32'd50; bus.divisor = 32'd7; end
      if (i == 2) begin
        checks++;
        if (bus.busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_mid_op got %b want 1", bus.busy);
        end
      end
      if (bus.done === 1'b1) begin
        ndone++;
        if (ndone == 1) begin lat = i; h = bus.hi; l = bus.lo; end
      end
    end
    checks++;
    if (ndone !== 1 || lat !== 7 || l !== 32'd3 || h !== 32'd2) begin
      errors++;
      $display("FAIL start_ignored got dones=%0d lat=%0d lo=%h hi=%h want 1 7 00000003 00000002",
               ndone, lat, l, h);
    end
  endtask

  task automatic test_back_to_back();
    int ndone = 0; int lat1 = 0, lat2 = 0;
    logic [31:0] h1 = 32'd0, l1 = 32'd0, h2 = 32'd0, l2 = 32'd0;
    @(negedge clk);
    bus.start = 1'b1; bus.signed_op = 1'b0; bus.dividend = 32'd20; bus.divisor = 32'd6;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (i == 3) begin bus.dividend = 32'd50; bus.divisor = 32'd7; end
      if (i == 15) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        ndone++;
        if (ndone == 1) begin lat1 = i; h1 = bus.hi; l1 = bus.lo; end
        if (ndone == 2) begin lat2 = i; h2 = bus.hi; l2 = bus.lo; end
      end
    end
    checks++;
    if (ndone !== 2 || lat1 !== 7 || lat2 !== 15) begin
      errors++;
      $display("FAIL b2b_timing got dones=%0d at %0d,%0d want 2 at 7,15", ndone, lat1, lat2);
    end
    checks++;
    if (l1 !== 32'd3 || h1 !== 32'd2 || l2 !== 32'd7 || h2 !== 32'd1) begin
      errors++;
      $display("FAIL b2b_values got %h/%h %h/%h want 00000003/00000002 00000007/00000001",
               l1, h1, l2, h2);
    end
  endtask

  task automatic test_reset_mid_op();
    int ndone = 0; int lat; logic [31:0] h, l; logic z;
    @(negedge clk);
    bus.start = 1'b1; bus.signed_op = 1'b0; bus.dividend = 32'd100; bus.divisor = 32'd7;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.dz, bus.hi, bus.lo} !== 67'd0) begin
      errors++;
      $display("FAIL reset_mid_op busy=%b done=%b dz=%b hi=%h lo=%h want all zero",
               bus.busy, bus.done, bus.dz, bus.hi, bus.lo);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.lo !== 32'd0 || bus.hi !== 32'd0) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errors++;
      $display("FAIL reset_no_done got %0d done/update cycles want 0", ndone);
    end
    run_op(1'b0, 32'd9, 32'd3, lat, h, l, z);
    checks++;
    if (lat !== 7 || l !== 32'd3 || h !== 32'd0 || z !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_op got lat=%0d lo=%h hi=%h dz=%b want 7 00000003 00000000 0", lat, l, h, z);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_arith();
    test_div_zero();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
